rx_block_lock: RTL and testbench

RX_BLOCK_LOCK -- requirements
Module: rx_block_lock

---
 rtl/rx_block_lock_if.sv | 30 +++
 rtl/rx_block_lock.sv | 157 +++++++++++++++
 tb/tb_rx_block_lock.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_lock_if.sv
// rx_block_lock_if
// Groups the block-lock datapath and status signals.
//   data_in    [65:0]  block from the RX gearbox, sync header in [1:0]
//   valid_in           data_in holds a new block this cycle
//   bitslip            one-cycle pulse asking the gearbox to shift by one bit
//   block_lock         high while block alignment is held
//   data_out   [65:0]  registered copy of data_in
//   valid_out          data_out valid and aligned
//   hdr_err            one-cycle pulse, accepted block had an invalid header
// slave  : the lock block itself
// master : the gearbox/consumer side driving data_in/valid_in
interface rx_block_lock_if;
    logic [65:0] data_in;
    logic        valid_in;
    logic        bitslip;
    logic        block_lock;
    logic [65:0] data_out;
    logic        valid_out;
    logic        hdr_err;

    modport slave (
        input  data_in, valid_in,
        output bitslip, block_lock, data_out, valid_out, hdr_err
    );

    modport master (
        output data_in, valid_in,
        input  bitslip, block_lock, data_out, valid_out, hdr_err
    );
endinterface

// File: rtl/rx_block_lock.sv
// rx_block_lock
// 64b/66b sync-header block lock state machine. Hunts for LOCK_CNT
// consecutive valid headers, requests a bitslip from the gearbox on any
// invalid header while hunting, and drops lock when INVLD_MAX invalid
// headers are seen inside one WINDOW-header test window.
// Ports:
//   clk      gearbox output clock
//   reset_n  asynchronous active-low reset
//   rx       rx_block_lock_if.slave (data_in/valid_in in, status out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | counting consecutive valid headers towards lock
// SLIP   | invalid header seen; bitslip is issued on leaving this state
// WAIT   | discarding SLIP_WAIT valid blocks while the gearbox settles
// LOCKED | aligned; counting invalid headers per test window
module rx_block_lock #(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 1024,
    parameter int INVLD_MAX = 65,
    parameter int SLIP_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    rx_block_lock_if.slave rx
);

    localparam int SH_W   = $clog2(WINDOW) + 1;
    localparam int INV_W  = $clog2(INVLD_MAX) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [SH_W-1:0]   LOCK_LAST = SH_W'(LOCK_CNT - 1);
    localparam logic [SH_W-1:0]   WIN_LIM   = SH_W'(WINDOW);
    localparam logic [INV_W-1:0]  INVLD_LIM = INV_W'(INVLD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]    sh_invld_cnt_q, sh_invld_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bitslip_q, bitslip_d;
    logic                valid_out_q, valid_out_d;
    logic                hdr_err_q, hdr_err_d;
    logic [65:0]         data_out_q, data_out_d;

    logic                hdr_bad;
    logic [SH_W-1:0]     sh_cnt_inc;
    logic [INV_W-1:0]    sh_invld_inc;

    assign hdr_bad      = (rx.data_in[1:0] == 2'b00) || (rx.data_in[1:0] == 2'b11);
    assign sh_cnt_inc   = sh_cnt_q + SH_W'(1);
    assign sh_invld_inc = sh_invld_cnt_q + INV_W'(hdr_bad);

    always_comb begin
        state_d        = state_q;
        sh_cnt_d       = sh_cnt_q;
        sh_invld_cnt_d = sh_invld_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        hdr_err_d      = 1'b0;
        // bitslip is registered off the SLIP state so it lands one cycle
        // after the header error that caused it
        bitslip_d      = (state_q == SLIP);
        valid_out_d    = rx.valid_in && (state_q == LOCKED);
        data_out_d     = rx.valid_in ? rx.data_in : data_out_q;

        case (state_q)
            HUNT: begin
                if (rx.valid_in) begin
                    if (hdr_bad) begin
                        hdr_err_d      = 1'b1;
                        state_d        = SLIP;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else if (sh_cnt_q == LOCK_LAST) begin
                        state_d        = LOCKED;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                    end
                end
            end
            SLIP: begin
                state_d        = WAIT;
                wait_cnt_d     = '0;
                sh_cnt_d       = '0;
                sh_invld_cnt_d = '0;
            end
            WAIT: begin
                if (rx.valid_in) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = HUNT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (rx.valid_in) begin
                    hdr_err_d = hdr_bad;
                    // loss of lock is checked first so it wins over window end
                    if (sh_invld_inc == INVLD_LIM) begin
                        state_d        = SLIP;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else if (sh_cnt_inc == WIN_LIM) begin
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d       = sh_cnt_inc;
                        sh_invld_cnt_d = sh_invld_inc;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HUNT;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            wait_cnt_q     <= '0;
            bitslip_q      <= 1'b0;
            valid_out_q    <= 1'b0;
            hdr_err_q      <= 1'b0;
            data_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            bitslip_q      <= bitslip_d;
            valid_out_q    <= valid_out_d;
            hdr_err_q      <= hdr_err_d;
            data_out_q     <= data_out_d;
        end
    end

    assign rx.block_lock = (state_q == LOCKED);
    assign rx.bitslip    = bitslip_q;
    assign rx.valid_out  = valid_out_q;
    assign rx.hdr_err    = hdr_err_q;
    assign rx.data_out   = data_out_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// tb_rx_block_lock
// Randomized bench for rx_block_lock with a behavioural lock model and a
// behavioural gearbox that honours bitslip.
module tb_rx_block_lock;

    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 1024;
    localparam int INVLD_MAX = 65;
    localparam int SLIP_WAIT = 4;
    localparam int NB        = 1500;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rx_block_lock_if bus();

    rx_block_lock #(
        .LOCK_CNT (LOCK_CNT),
        .WINDOW   (WINDOW),
        .INVLD_MAX(INVLD_MAX),
        .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rx     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int n_slip = 0;
    int n_herr = 0;

    // behavioural model: lock flag, run of good headers, blocks still to
    // discard after a slip, pending slip request, window statistics
    bit          m_locked;
    bit          m_slip_req;
    int          m_good;
    int          m_skip;
    int          m_win_n;
    int          m_win_bad;
    bit          e_bitslip;
    bit          e_hdr_err;
    bit          e_valid_out;
    logic [65:0] e_data;

    logic [65:0] blks [NB];

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_slip_req  = 1'b0;
        m_good      = 0;
        m_skip      = 0;
        m_win_n     = 0;
        m_win_bad   = 0;
        e_bitslip   = 1'b0;
        e_hdr_err   = 1'b0;
        e_valid_out = 1'b0;
        e_data      = '0;
    endtask

    task automatic model_tick(input bit v, input logic [65:0] d);
        bit bad;
        bad         = (d[1:0] == 2'b00) || (d[1:0] == 2'b11);
        e_hdr_err   = 1'b0;
        e_bitslip   = m_slip_req;
        e_valid_out = v && m_locked;
        if (v) e_data = d;
        if (m_slip_req) begin
            m_slip_req = 1'b0;
            m_skip     = SLIP_WAIT;
        end else if (m_skip > 0) begin
            if (v) m_skip--;
        end else if (v) begin
            e_hdr_err = bad;
            if (!m_locked) begin
                if (bad) begin
                    m_slip_req = 1'b1;
                    m_good     = 0;
                end else begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_locked  = 1'b1;
                        m_good    = 0;
                        m_win_n   = 0;
                        m_win_bad = 0;
                    end
                end
            end else begin
                m_win_n++;
                if (bad) m_win_bad++;
                if (m_win_bad == INVLD_MAX) begin
                    m_locked   = 1'b0;
                    m_slip_req = 1'b1;
                    m_win_n    = 0;
                    m_win_bad  = 0;
                end else if (m_win_n == WINDOW) begin
                    m_win_n   = 0;
                    m_win_bad = 0;
                end
            end
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [65:0] mk_blk(input logic [1:0] h);
        logic [65:0] b;
        b[31:0]  = $urandom();
        b[63:32] = $urandom();
        b[65:64] = 2'($urandom_range(0, 3));
        b[1:0]   = h;
        return b;
    endfunction

    task automatic step(input bit v, input logic [65:0] d);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk);
        model_tick(v, d);
        #1;
        chk("block_lock", 66'(bus.block_lock), 66'(m_locked));
        chk("bitslip",    66'(bus.bitslip),    66'(e_bitslip));
        chk("hdr_err",    66'(bus.hdr_err),    66'(e_hdr_err));
        chk("valid_out",  66'(bus.valid_out),  66'(e_valid_out));
        chk("data_out",   bus.data_out,        e_data);
        if (bus.bitslip) n_slip++;
        if (bus.hdr_err) n_herr++;
    endtask

    task automatic send(input bit bad);
        while ($urandom_range(0, 7) == 0) step(1'b0, mk_blk(2'b11));
        step(1'b1, mk_blk(bad ? bad_hdr() : good_hdr()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n      = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        chk("rst_block_lock", 66'(bus.block_lock), 66'(0));
        chk("rst_bitslip",    66'(bus.bitslip),    66'(0));
        chk("rst_hdr_err",    66'(bus.hdr_err),    66'(0));
        chk("rst_valid_out",  66'(bus.valid_out),  66'(0));
        chk("rst_data_out",   bus.data_out,        66'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_slip  = 0;
        n_herr  = 0;
    endtask

    task automatic acquire();
        repeat (LOCK_CNT) send(1'b0);
        chk("acquire", 66'(bus.block_lock), 66'(1));
    endtask

    task automatic run_window(input int n_bad, input bit last_bad);
        bit pos [WINDOW];
        int cnt;
        int top;
        int p;
        for (int i = 0; i < WINDOW; i++) pos[i] = 1'b0;
        top = last_bad ? WINDOW - 2 : WINDOW - 1;
        cnt = 0;
        while (cnt < n_bad) begin
            p = $urandom_range(0, top);
            if (!pos[p]) begin
                pos[p] = 1'b1;
                cnt++;
            end
        end
        if (last_bad) pos[WINDOW-1] = 1'b1;
        for (int i = 0; i < WINDOW; i++) send(pos[i]);
    endtask

    task automatic gearbox_run(input int k);
        int          pos;
        int          cyc;
        bit          v;
        logic [65:0] d;
        do_reset();
        for (int j = 0; j < NB; j++) blks[j] = mk_blk(good_hdr());
        pos = (66 - k) % 66;
        cyc = 0;
        while (!bus.block_lock && cyc < 2500 && pos + 66 < NB * 66) begin
            v = ($urandom_range(0, 7) != 0);
            if (v) begin
                for (int i = 0; i < 66; i++) d[i] = blks[(pos + i) / 66][(pos + i) % 66];
                pos += 66;
            end else begin
                d = mk_blk(2'b00);
            end
            step(v, d);
            if (bus.bitslip) pos += 1;
            cyc++;
        end
        chk("gb_lock",  66'(bus.block_lock), 66'(1));
        chk("gb_slips", 66'(n_slip),         66'(k));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int ks [6];
        reset_n      = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_reset();

        // clean acquisition: exactly LOCK_CNT blocks
        do_reset();
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(1'b1, mk_blk(good_hdr()));
            if (i == LOCK_CNT - 2) chk("lock_early", 66'(bus.block_lock), 66'(0));
        end
        chk("lock_rise", 66'(bus.block_lock), 66'(1));
        chk("lock_no_slip", 66'(n_slip), 66'(0));

        // invalid header while hunting, discarded blocks, restart from 0
        do_reset();
        repeat (10) step(1'b1, mk_blk(good_hdr()));
        step(1'b1, mk_blk(2'b11));
        chk("hunt_hdr_err", 66'(bus.hdr_err), 66'(1));
        chk("hunt_slip_not_yet", 66'(bus.bitslip), 66'(0));
        step(1'b0, mk_blk(2'b00));
        chk("hunt_slip", 66'(bus.bitslip), 66'(1));
        repeat (SLIP_WAIT) step(1'b1, mk_blk(bad_hdr()));
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(1'b1, mk_blk(good_hdr()));
            if (i == LOCK_CNT - 2) chk("relock_early", 66'(bus.block_lock), 66'(0));
        end
        chk("relock", 66'(bus.block_lock), 66'(1));
        chk("hunt_err_count", 66'(n_herr), 66'(1));
        chk("hunt_slip_count", 66'(n_slip), 66'(1));

        // reset while a slip is pending
        do_reset();
        repeat (5) step(1'b1, mk_blk(good_hdr()));
        step(1'b1, mk_blk(2'b00));
        do_reset();
        step(1'b1, mk_blk(good_hdr()));
        chk("no_slip_after_rst", 66'(bus.bitslip), 66'(0));

        // INVLD_MAX invalid headers inside one window
        do_reset();
        acquire();
        begin
            bit pos [WINDOW];
            int cnt;
            int p;
            for (int i = 0; i < WINDOW; i++) pos[i] = 1'b0;
            cnt = 0;
            while (cnt < INVLD_MAX) begin
                p = $urandom_range(0, WINDOW - 1);
                if (!pos[p]) begin
                    pos[p] = 1'b1;
                    cnt++;
                end
            end
            nb = 0;
            for (int i = 0; i < WINDOW; i++) begin
                send(pos[i]);
                if (pos[i]) begin
                    nb++;
                    if (nb == INVLD_MAX) break;
                end
            end
        end
        chk("loss_65", 66'(bus.block_lock), 66'(0));
        step(1'b0, mk_blk(2'b00));
        chk("loss_slip", 66'(bus.bitslip), 66'(1));

        // INVLD_MAX-1 invalid per window for three windows keeps lock
        do_reset();
        acquire();
        n_herr = 0;
        for (int w = 0; w < 3; w++) begin
            run_window(INVLD_MAX - 1, 1'b0);
            chk("lock_hold", 66'(bus.block_lock), 66'(1));
        end
        chk("hold_err_count", 66'(n_herr), 66'(3 * (INVLD_MAX - 1)));
        chk("hold_no_slip", 66'(n_slip), 66'(0));

        // last block of the window is also the INVLD_MAX-th invalid header
        do_reset();
        acquire();
        run_window(INVLD_MAX - 1, 1'b1);
        chk("loss_at_window_end", 66'(bus.block_lock), 66'(0));
        step(1'b0, mk_blk(2'b00));
        chk("loss_end_slip", 66'(bus.bitslip), 66'(1));

        // misaligned stream through a bit-level gearbox
        ks[0] = 0;
        ks[1] = 1;
        ks[2] = 2;
        ks[3] = 33;
        ks[4] = 65;
        ks[5] = int'($urandom_range(3, 64));
        for (int i = 0; i < 6; i++) gearbox_run(ks[i]);

        // free-running random traffic alternating clean and noisy phases
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int rate;
            bit v;
            bit bad;
            rate = (((i / 1000) % 2) == 1) ? 12 : 400;
            v    = ($urandom_range(0, 7) != 0);
            bad  = ($urandom_range(0, rate - 1) == 0);
            step(v, mk_blk(bad ? bad_hdr() : good_hdr()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
